// File: rtl/bp_pkg.sv
// Shared types and constants for the fetch-side branch predictor.
// Optional performance counters in the top are enabled with BP_PERF_CNT_EN.
package bp_pkg;

    localparam int BP_ENTRIES_DEFAULT = 64;

    // Smallest legal table (4 entries) leaves 28 tag bits, so that is the widest tag.
    localparam int BP_TAG_W_MAX = 28;

    typedef enum logic [1:0] {
        CNT_SNT = 2'b00,
        CNT_WNT = 2'b01,
        CNT_WT  = 2'b10,
        CNT_ST  = 2'b11
    } cnt_state_e;

    typedef struct packed {
        logic                    valid;
        logic [BP_TAG_W_MAX-1:0] tag;
        logic [31:0]             target;
    } btb_entry_t;

endpackage

// File: rtl/bp_sat_counter.sv
// Combinational next-state for a 2-bit saturating direction counter.
module bp_sat_counter
    import bp_pkg::*;
(
    input  cnt_state_e state_i,
    input  logic       taken_i,
    output cnt_state_e next_o
);

    always_comb begin
        next_o = state_i;
        if (taken_i) begin
            if (state_i != CNT_ST) begin
                next_o = cnt_state_e'(state_i + 2'd1);
            end
        end else begin
            if (state_i != CNT_SNT) begin
                next_o = cnt_state_e'(state_i - 2'd1);
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: 2-bit counter table plus direct-mapped BTB, trained from EX.
// Define BP_PERF_CNT_EN to add the perf_branches / perf_mispredicts counters.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = BP_ENTRIES_DEFAULT,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int TAG_W   = 30 - IDX_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    output logic        if_pred_taken,
    output logic [31:0] if_pred_target,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc
`ifdef BP_PERF_CNT_EN
    ,
    output logic [31:0] perf_branches,
    output logic [31:0] perf_mispredicts
`endif
);

    cnt_state_e cnt_q [ENTRIES];
    btb_entry_t btb_q [ENTRIES];

    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    btb_entry_t       if_entry;
    logic             if_btb_hit;
    cnt_state_e       ex_cnt_d;
    logic             upd_en;
    logic [31:0]      ex_pc_plus4;
    logic             unused_pc_lsbs;

    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc[31:IDX_W+2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_tag = ex_pc[31:IDX_W+2];
    assign unused_pc_lsbs = ^{if_pc[1:0], ex_pc[1:0]};

    assign upd_en      = ex_valid & ex_is_branch;
    assign ex_pc_plus4 = ex_pc + 32'd4;

    // Stored tags are zero-extended, so a full-width compare is exact.
    assign if_entry       = btb_q[if_idx];
    assign if_btb_hit     = if_entry.valid && (if_entry.tag == BP_TAG_W_MAX'(if_tag));
    assign if_pred_taken  = cnt_q[if_idx][1] & if_btb_hit;
    assign if_pred_target = if_pred_taken ? if_entry.target : (if_pc + 32'd4);

    bp_sat_counter u_sat_counter (
        .state_i (cnt_q[ex_idx]),
        .taken_i (ex_taken),
        .next_o  (ex_cnt_d)
    );

    // Lookup reads the arrays combinationally, so a same-index update is seen next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                cnt_q[i]       <= CNT_WNT;
                btb_q[i].valid <= 1'b0;
            end
        end else if (upd_en) begin
            cnt_q[ex_idx] <= ex_cnt_d;
            if (ex_taken) begin
                btb_q[ex_idx] <= '{valid: 1'b1, tag: BP_TAG_W_MAX'(ex_tag), target: ex_target};
            end
        end
    end

    always_comb begin
        mispredict  = upd_en & ((ex_taken != ex_pred_taken) |
                               (ex_taken & ex_pred_taken & (ex_target != ex_pred_target)));
        redirect_pc = 32'd0;
        if (mispredict) begin
            redirect_pc = ex_taken ? ex_target : ex_pc_plus4;
        end
    end

`ifdef BP_PERF_CNT_EN
    logic [31:0] perf_branches_q;
    logic [31:0] perf_mispredicts_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_branches_q    <= 32'd0;
            perf_mispredicts_q <= 32'd0;
        end else begin
            if (upd_en) begin
                perf_branches_q <= perf_branches_q + 32'd1;
            end
            if (mispredict) begin
                perf_mispredicts_q <= perf_mispredicts_q + 32'd1;
            end
        end
    end

    assign perf_branches    = perf_branches_q;
    assign perf_mispredicts = perf_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus randomized traffic.
module tb_branch_predictor;

    localparam int ENT  = 64;
    localparam int IDXW = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic [31:0] if_pred_target;
    logic        ex_valid;
    logic        ex_is_branch;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
`ifdef BP_PERF_CNT_EN
    logic [31:0] perf_branches;
    logic [31:0] perf_mispredicts;
`endif

    always #5 clk = ~clk;

    branch_predictor #(.ENTRIES(ENT)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_pc          (if_pc),
        .if_pred_taken  (if_pred_taken),
        .if_pred_target (if_pred_target),
        .ex_valid       (ex_valid),
        .ex_is_branch   (ex_is_branch),
        .ex_pc          (ex_pc),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .mispredict     (mispredict),
        .redirect_pc    (redirect_pc)
`ifdef BP_PERF_CNT_EN
        ,
        .perf_branches    (perf_branches),
        .perf_mispredicts (perf_mispredicts)
`endif
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model: counters as plain integers 0..3, BTB as parallel arrays.
    int          m_cnt [ENT];
    bit          m_val [ENT];
    bit [31:0]   m_tag [ENT];
    bit [31:0]   m_tgt [ENT];
    bit [31:0]   m_perf_br;
    bit [31:0]   m_perf_mis;

    function automatic int idx_of(input bit [31:0] pc);
        return int'((pc >> 2) % ENT);
    endfunction

    function automatic bit [31:0] tag_of(input bit [31:0] pc);
        return pc >> (2 + IDXW);
    endfunction

    function automatic bit m_pred(input bit [31:0] pc);
        int i;
        i = idx_of(pc);
        return (m_cnt[i] >= 2) && m_val[i] && (m_tag[i] == tag_of(pc));
    endfunction

    function automatic bit [31:0] m_ptgt(input bit [31:0] pc);
        return m_pred(pc) ? m_tgt[idx_of(pc)] : pc + 32'd4;
    endfunction

    function automatic bit m_mis();
        if (!(ex_valid && ex_is_branch)) return 1'b0;
        if (ex_taken != ex_pred_taken) return 1'b1;
        return ex_taken && (ex_target != ex_pred_target);
    endfunction

    function automatic bit [31:0] m_redir();
        if (!m_mis()) return 32'd0;
        return ex_taken ? ex_target : ex_pc + 32'd4;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENT; i++) begin
                m_cnt[i] <= 1;
                m_val[i] <= 1'b0;
            end
            m_perf_br  <= 32'd0;
            m_perf_mis <= 32'd0;
        end else begin
            if (ex_valid && ex_is_branch) begin
                m_cnt[idx_of(ex_pc)] <= ex_taken ? ((m_cnt[idx_of(ex_pc)] < 3) ? m_cnt[idx_of(ex_pc)] + 1 : 3)
                                                 : ((m_cnt[idx_of(ex_pc)] > 0) ? m_cnt[idx_of(ex_pc)] - 1 : 0);
                if (ex_taken) begin
                    m_val[idx_of(ex_pc)] <= 1'b1;
                    m_tag[idx_of(ex_pc)] <= tag_of(ex_pc);
                    m_tgt[idx_of(ex_pc)] <= ex_target;
                end
                m_perf_br <= m_perf_br + 32'd1;
            end
            if (m_mis()) m_perf_mis <= m_perf_mis + 32'd1;
        end
    end

    // Compare process: every falling edge once the first reset has been applied.
    always @(negedge clk) begin
        if (chk_en) begin
            check("pred_taken",  {31'd0, if_pred_taken}, {31'd0, m_pred(if_pc)});
            check("pred_target", if_pred_target, m_ptgt(if_pc));
            check("mispredict",  {31'd0, mispredict}, {31'd0, m_mis()});
            check("redirect_pc", redirect_pc, m_redir());
`ifdef BP_PERF_CNT_EN
            check("perf_branches",    perf_branches,    m_perf_br);
            check("perf_mispredicts", perf_mispredicts, m_perf_mis);
`endif
        end
    end

    task automatic set_ex(input bit v, input bit br, input bit [31:0] pc, input bit tk,
                          input bit [31:0] tgt, input bit ptk, input bit [31:0] ptgt);
        ex_valid       = v;
        ex_is_branch   = br;
        ex_pc          = pc;
        ex_taken       = tk;
        ex_target      = tgt;
        ex_pred_taken  = ptk;
        ex_pred_target = ptgt;
    endtask

    task automatic idle_ex();
        set_ex(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    // Sample point for literal checks, then advance to just after the next rising edge.
    task automatic to_sample();
        @(negedge clk);
        #1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic lit_pred(input string name, input bit tk, input bit [31:0] tgt);
        to_sample();
        check({name, "_taken"},  {31'd0, if_pred_taken}, {31'd0, tk});
        check({name, "_target"}, if_pred_target, tgt);
        next_cycle();
    endtask

    bit [31:0] pool [8] = '{32'h0000_0100, 32'h0000_0200, 32'h0000_0300, 32'h0000_0104,
                            32'h0000_1108, 32'h8000_0010, 32'hFFFF_FFFC, 32'h0000_0010};

    initial begin
        rst   = 1'b1;
        if_pc = 32'h0000_0100;
        idle_ex();
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;

        // Post-reset lookup
        to_sample();
        check("rst_taken",  {31'd0, if_pred_taken}, 32'd0);
        check("rst_target", if_pred_target, 32'h0000_0104);
        check("rst_mis",    {31'd0, mispredict}, 32'd0);
        next_cycle();

        // Train 0x100 taken -> 0x80
        set_ex(1'b1, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        to_sample();
        check("train_mis",   {31'd0, mispredict}, 32'd1);
        check("train_redir", redirect_pc, 32'h80);
        check("train_old",   {31'd0, if_pred_taken}, 32'd0);
        next_cycle();
        idle_ex();
        lit_pred("trained", 1'b1, 32'h80);

        // Alias at same index, different tag
        if_pc = 32'h200;
        lit_pred("alias", 1'b0, 32'h204);

        // Saturation on 0x200
        for (int k = 0; k < 4; k++) begin
            set_ex(1'b1, 1'b1, 32'h200, 1'b1, 32'h280, 1'b1, 32'h280);
            next_cycle();
        end
        set_ex(1'b1, 1'b1, 32'h200, 1'b0, 32'h280, 1'b1, 32'h280);
        next_cycle();
        idle_ex();
        lit_pred("sat_nt1", 1'b1, 32'h280);
        set_ex(1'b1, 1'b1, 32'h200, 1'b0, 32'h280, 1'b1, 32'h280);
        next_cycle();
        idle_ex();
        lit_pred("sat_nt2", 1'b0, 32'h204);

        // Same-cycle read/write at 0x300
        if_pc = 32'h300;
        set_ex(1'b1, 1'b1, 32'h300, 1'b1, 32'h500, 1'b0, 32'h304);
        lit_pred("rdw_old", 1'b0, 32'h304);
        idle_ex();
        lit_pred("rdw_new", 1'b1, 32'h500);

        // Reset beats a simultaneous update
        rst = 1'b1;
        set_ex(1'b1, 1'b1, 32'h300, 1'b1, 32'h600, 1'b1, 32'h500);
        next_cycle();
        rst = 1'b0;
        idle_ex();
        lit_pred("rst_upd", 1'b0, 32'h304);
        set_ex(1'b1, 1'b1, 32'h300, 1'b1, 32'h600, 1'b0, 32'h304);
        next_cycle();
        idle_ex();
        lit_pred("rst_cnt01", 1'b1, 32'h600);

        // PC wrap and target mismatch
        set_ex(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h40, 1'b1, 32'h40);
        to_sample();
        check("wrap_mis",   {31'd0, mispredict}, 32'd1);
        check("wrap_redir", redirect_pc, 32'h0000_0000);
        next_cycle();
        set_ex(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h44, 1'b1, 32'h40);
        to_sample();
        check("tgt_mis",   {31'd0, mispredict}, 32'd1);
        check("tgt_redir", redirect_pc, 32'h44);
        next_cycle();
        set_ex(1'b0, 1'b1, 32'h100, 1'b1, 32'h44, 1'b0, 32'h40);
        to_sample();
        check("bubble_mis",   {31'd0, mispredict}, 32'd0);
        check("bubble_redir", redirect_pc, 32'd0);
        next_cycle();

        // Randomized traffic over a small PC pool so hits and aliases are frequent
        for (int n = 0; n < 3000; n++) begin
            bit [31:0] epc;
            bit [31:0] etg;
            bit        etk;
            epc = pool[$urandom_range(0, 7)];
            etg = {$urandom_range(0, 15), 2'b00} << 4;
            etk = 1'($urandom_range(0, 1));
            if_pc = ($urandom_range(0, 3) == 0) ? {$urandom()} & 32'hFFFF_FFFC : pool[$urandom_range(0, 7)];
            rst   = ($urandom_range(0, 199) == 0);
            set_ex(($urandom_range(0, 3) != 0), ($urandom_range(0, 4) != 0), epc, etk, etg,
                   ($urandom_range(0, 1) == 1) ? m_pred(epc) : 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 1) == 1) ? m_ptgt(epc) : etg);
            next_cycle();
        end
        rst = 1'b0;
        idle_ex();
        next_cycle();
        to_sample();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
